ddr_rd_arbiter: RTL
===================

DDR_RD_ARBITER -- requirements
Module: ddr_rd_arbiter

Interface
REQ-001 SHALL have parameter NUM_SLV, default 4, number of read requesters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 25, DDR word address width.
REQ-003 SHALL have parameter LEN_W, default 10, burst length width in words.
REQ-004 SHALL have parameter DATA_W, default 32, data width.
REQ-005 SHALL have parameter TMO_CYC, default 4096, watchdog limit in ddr_clk cycles.
REQ-006 SHALL have port ddr_clk, input, 1 bit, the clock.
REQ-007 SHALL have port sys_rstn, input, 1 bit, reset: asynchronous, active-low.
REQ-008 SHALL have port slv_req, input, NUM_SLV bits, per-requester level read request.
REQ-009 SHALL have port slv_raddr, input, NUM_SLV*ADDR_W bits, packed start addresses; slave i occupies bits [i*ADDR_W +: ADDR_W].
REQ-010 SHALL have port slv_rlen, input, NUM_SLV*LEN_W bits, packed burst lengths.
REQ-011 SHALL have port slv_grant, output, NUM_SLV bits, one-hot owner of the current burst.
REQ-012 SHALL have port slv_wen, output, NUM_SLV bits, per-requester FIFO write enable.
REQ-013 SHALL have port slv_wdata, output, DATA_W bits, shared data to requester FIFOs.
REQ-014 SHALL have port slv_done, output, NUM_SLV bits, one-cycle completion pulse.
REQ-015 SHALL have port ready, input, 1 bit, DDR read controller idle.
REQ-016 SHALL have port rd_start, output, 1 bit, burst command.
REQ-017 SHALL have port rd_ack, input, 1 bit, command accepted.
REQ-018 SHALL have port rd_addr, output, ADDR_W bits, burst address.
REQ-019 SHALL have port rd_len, output, LEN_W bits, burst length.
REQ-020 SHALL have port ddr_rvalid, input, 1 bit, read data beat valid.
REQ-021 SHALL have port ddr_rdata, input, DATA_W bits, read data.
REQ-022 SHALL have port ddr_read_finish, input, 1 bit, burst end pulse.
REQ-023 SHALL have port tmo_err, output, 1 bit, sticky watchdog flag.

Function
REQ-024 SHALL use FSM states IDLE, ARB, CMD, XFER, DONE.
REQ-025 SHALL transition IDLE->ARB when any slv_req is high.
REQ-026 SHALL, in ARB, select round-robin starting at index (last_grant+1) mod NUM_SLV, latch the selected address/length into rd_addr/rd_len, and set slv_grant in the same edge.
REQ-027 SHALL, when the latched length is 0, skip DDR and go ARB->DONE.
REQ-028 SHALL, in CMD, assert rd_start only while ready=1 and hold it until rd_ack; on rd_ack go to XFER.
REQ-029 SHALL, in XFER, route ddr_rvalid combinationally to slv_wen of the granted slave only, set slv_wdata=ddr_rdata, and count beats.
REQ-030 SHALL leave XFER for DONE on ddr_read_finish, or when the beat count equals rd_len, whichever comes first.
REQ-031 SHALL, in DONE, pulse slv_done for the owner for one cycle, update last_grant, clear slv_grant, and return to IDLE; minimum of one IDLE cycle between bursts.
REQ-032 SHALL ignore slv_req deassertion after grant; the burst completes regardless.
REQ-033 SHALL drop ddr_rvalid beats received outside XFER, with no slv_wen.
REQ-034 SHALL keep a beat counter of LEN_W+1 bits that saturates and does not wrap.

Reset
REQ-035 SHALL, on sys_rstn low at any time (including mid-burst), force IDLE immediately.
REQ-036 SHALL reset to: slv_grant=0, slv_done=0, rd_start=0, rd_addr=0, rd_len=0, tmo_err=0, beat count=0.
REQ-037 SHALL reset last_grant to NUM_SLV-1, so slave 0 wins first.

Configuration
REQ-038 SHALL, with ARB_TIMEOUT_EN defined, count cycles spent in CMD+XFER; at TMO_CYC it SHALL set tmo_err, pulse slv_done, and return to IDLE.
REQ-039 SHALL, without ARB_TIMEOUT_EN, omit the watchdog counter, tie tmo_err to 0, and wait indefinitely.

Structure
REQ-040 SHALL take the FSM state enum and default widths from a shared package ddr_arb_pkg.
REQ-041 SHALL implement round-robin selection as sub-module rr_pick, with inputs req and last and output a one-hot grant.

Verification
REQ-042 SHALL cover: slv_req=4'b0101 held high -> grants alternate slave0, slave2, slave0.
REQ-043 SHALL cover: slave1 addr 0x100, len 8, 8 rvalid beats then finish -> 8 slv_wen[1] pulses, then one slv_done[1] pulse.
REQ-044 SHALL cover: len=0 request -> slv_done with no rd_start.
REQ-045 SHALL cover: ready=0 for 20 cycles -> rd_start stays 0, then asserts and holds until rd_ack.
REQ-046 SHALL cover: reset mid-XFER after 3 beats -> all outputs 0 and next grant goes to slave0.
REQ-047 SHALL cover, with ARB_TIMEOUT_EN and TMO_CYC=64, no rd_ack -> tmo_err=1 at cycle 64 and the FSM returns to IDLE.

Source files
------------

// File: rtl/ddr_arb_pkg.sv
// Shared definitions for the DDR read arbiter: FSM state encoding and
// default parameter values used by ddr_rd_arbiter and rr_pick.
package ddr_arb_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARB  = 3'd1,
        CMD  = 3'd2,
        XFER = 3'd3,
        DONE = 3'd4
    } arb_state_e;

    localparam int DEF_NUM_SLV = 4;
    localparam int DEF_ADDR_W  = 25;
    localparam int DEF_LEN_W   = 10;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_TMO_CYC = 4096;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: searches requesters starting one past the last owner
// and returns a one-hot grant (all zero when nobody requests).
module rr_pick
    import ddr_arb_pkg::*;
#(
    parameter int NUM_SLV = DEF_NUM_SLV,
    parameter int IDX_W   = $clog2(NUM_SLV)
) (
    input  logic [NUM_SLV-1:0] req,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_SLV-1:0] grant
);

    logic found;

    // First requester found walking from last+1 (wrapping) wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int off = 1; off <= NUM_SLV; off++) begin
            for (int j = 0; j < NUM_SLV; j++) begin
                if (!found && req[j] && (j == (int'(last) + off) % NUM_SLV)) begin
                    grant[j] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ddr_rd_arbiter.sv
// DDR read arbiter: shares one DDR read controller between NUM_SLV
// requesters, one burst at a time, round-robin.
// Optional watchdog on command/transfer time: define ARB_TIMEOUT_EN.
module ddr_rd_arbiter
    import ddr_arb_pkg::*;
#(
    parameter int NUM_SLV = DEF_NUM_SLV,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TMO_CYC = DEF_TMO_CYC
) (
    input  logic                      ddr_clk,
    input  logic                      sys_rstn,
    input  logic [NUM_SLV-1:0]        slv_req,
    input  logic [NUM_SLV*ADDR_W-1:0] slv_raddr,
    input  logic [NUM_SLV*LEN_W-1:0]  slv_rlen,
    output logic [NUM_SLV-1:0]        slv_grant,
    output logic [NUM_SLV-1:0]        slv_wen,
    output logic [DATA_W-1:0]         slv_wdata,
    output logic [NUM_SLV-1:0]        slv_done,
    input  logic                      ready,
    output logic                      rd_start,
    input  logic                      rd_ack,
    output logic [ADDR_W-1:0]         rd_addr,
    output logic [LEN_W-1:0]          rd_len,
    input  logic                      ddr_rvalid,
    input  logic [DATA_W-1:0]         ddr_rdata,
    input  logic                      ddr_read_finish,
    output logic                      tmo_err
);

    localparam int IDX_W = $clog2(NUM_SLV);

    arb_state_e         state, state_nxt;
    logic [IDX_W-1:0]   last_grant, grant_idx;
    logic [NUM_SLV-1:0] pick;
    logic [ADDR_W-1:0]  sel_addr;
    logic [LEN_W-1:0]   sel_len;
    logic [LEN_W:0]     beat_cnt, cnt_nxt;
    logic               xfer_end;
    logic               tmo_hit;

    rr_pick #(
        .NUM_SLV (NUM_SLV),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req   (slv_req),
        .last  (last_grant),
        .grant (pick)
    );

    // Mux the winner's address/length out of the packed request buses.
    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (pick[i]) begin
                sel_addr = slv_raddr[i*ADDR_W +: ADDR_W];
                sel_len  = slv_rlen[i*LEN_W +: LEN_W];
            end
        end
    end

    // Index of the current owner, recorded as last_grant when the burst ends.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (slv_grant[i]) grant_idx = IDX_W'(i);
        end
    end

    // Beat count saturates; the end test includes the beat arriving now so
    // no extra write enable leaks out after the last expected beat.
    assign cnt_nxt  = (&beat_cnt) ? beat_cnt : beat_cnt + 1'b1;
    assign xfer_end = ddr_read_finish || (ddr_rvalid && (cnt_nxt == {1'b0, rd_len}));

    // Next-state logic; ARB falls back to IDLE if the request vanished.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (|slv_req) state_nxt = ARB;
            ARB: begin
                if (pick == '0)           state_nxt = IDLE;
                else if (sel_len == '0)   state_nxt = DONE;
                else                      state_nxt = CMD;
            end
            CMD: begin
                if (tmo_hit)              state_nxt = DONE;
                else if (rd_ack)          state_nxt = XFER;
            end
            XFER: if (tmo_hit || xfer_end) state_nxt = DONE;
            DONE:                         state_nxt = IDLE;
            default:                      state_nxt = IDLE;
        endcase
    end

    // State, ownership, latched command and beat counter.
    always_ff @(posedge ddr_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state      <= IDLE;
            last_grant <= IDX_W'(NUM_SLV - 1);
            slv_grant  <= '0;
            rd_addr    <= '0;
            rd_len     <= '0;
            beat_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ARB && pick != '0) begin
                slv_grant <= pick;
                rd_addr   <= sel_addr;
                rd_len    <= sel_len;
                beat_cnt  <= '0;
            end
            if (state == XFER && ddr_rvalid) beat_cnt <= cnt_nxt;
            if (state == DONE) begin
                slv_grant  <= '0;
                last_grant <= grant_idx;
            end
        end
    end

    assign rd_start  = (state == CMD) && ready;
    assign slv_wen   = (state == XFER && ddr_rvalid) ? slv_grant : '0;
    assign slv_wdata = ddr_rdata;
    assign slv_done  = (state == DONE) ? slv_grant : '0;

`ifdef ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYC + 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_flag;

    assign tmo_hit = (state == CMD || state == XFER) && (tmo_cnt == TMO_W'(TMO_CYC - 1));

    // Watchdog: counts cycles spent waiting on the DDR side; flag is sticky.
    always_ff @(posedge ddr_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            tmo_cnt  <= '0;
            tmo_flag <= 1'b0;
        end else begin
            if (state == CMD || state == XFER) tmo_cnt <= tmo_cnt + 1'b1;
            else                               tmo_cnt <= '0;
            if (tmo_hit) tmo_flag <= 1'b1;
        end
    end

    assign tmo_err = tmo_flag;
`else
    assign tmo_hit = 1'b0;
    assign tmo_err = 1'b0;
`endif

endmodule
